taxi_led_status_ctrl: RTL and testbench
=======================================

Name: taxi_led_status_ctrl

Overview:
Multi-channel board status LED controller for the FPGA cores. It drives one heartbeat LED and CNT per-port LEDs, with run-time selectable modes, activity stretching, blinking and fault indication, all from a single prescaled millisecond timebase. It sits in fpga_core between the MAC/PHY status signals (already synchronous to clk) and the LED pins. It replaces the per-board ad hoc heartbeat counter and the direct rx_status-to-LED assignments.

Parameters:
CNT, 2, number of port LED channels (1..32)
CLK_FREQ_HZ, 125000000, clk frequency; DIV = CLK_FREQ_HZ/1000 cycles per ms tick
HB_PERIOD_MS, 1000, full heartbeat period in ms
BLINK_PERIOD_MS, 100, full activity/fault blink period in ms
ACT_HOLD_MS, 50, activity stretch in ms after the last act pulse
INVERT, 1'b1, 1 = LED outputs active-low
PWM_W, 4, brightness width (used only with LED_PWM_EN)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
lamp_test  in  1  forces all LEDs on
ch_mode[CNT]  in  2  per-channel mode: 0 off, 1 on, 2 link, 3 link+activity
ch_link[CNT]  in  1  link up
ch_act[CNT]  in  1  single-cycle activity pulse
ch_fault[CNT]  in  1  fault level
led_hb  out  1  heartbeat LED
led_ch[CNT]  out  1  port LEDs

Behaviour:
- Elaboration $error if DIV<2, HB_PERIOD_MS<2 or odd, BLINK_PERIOD_MS<2 or odd, ACT_HOLD_MS<1, or CNT outside 1..32.
- Define "off" as INVERT; "on" as !INVERT.
- While rst_n=0:
  - prescaler = DIV-1; hb_cnt = 0; hb_reg = 0; blink_cnt = 0; blink_ph = 0; all hold_cnt = 0.
  - All outputs = off; they are still off in the first cycle after release.
- Prescaler: decrements each cycle. At 0 it asserts tick for one cycle and reloads DIV-1. First tick occurs DIV-1 cycles after reset release (cycle index 0 = first cycle with rst_n=1).
- Heartbeat: on tick, if hb_cnt == HB_PERIOD_MS/2-1 then hb_cnt <= 0 and hb_reg toggles; else hb_cnt increments.
- Blink: identical scheme with BLINK_PERIOD_MS/2, toggling blink_ph.
- Activity, per channel:
  - ch_act=1 loads hold_cnt = ACT_HOLD_MS.
  - Otherwise, on tick, hold_cnt decrements, saturating at 0.
  - If ch_act and tick coincide, the load wins.
  - active = hold_cnt != 0.
- Channel LED on-condition, with priority:
  1. lamp_test
  2. mode 0 -> off
  3. ch_fault -> blink_ph (fault overrides modes 1-3)
  4. mode 1 -> on
  5. mode 2 -> ch_link
  6. mode 3 -> ch_link & (active ? !blink_ph : 1); the LED turns off immediately on the first blink phase.
- led_hb on-condition: lamp_test | hb_reg.
- Outputs are registered. Latency is 1 cycle from any state register or input to its LED pin. Mode, link and fault changes take effect on the pin exactly 1 cycle after being sampled, with no glitch.
- ch_mode changes mid-blink do not reset blink_ph or hold_cnt.
- Reset asserted mid-operation clears all state in that cycle. Outputs go off on the next edge.

Optional Feature:
- Macro: TAXI_LED_PWM_EN.
- When defined:
  - Adds input brightness [PWM_W-1:0].
  - Adds a free-running PWM_W-bit pwm_cnt, reset to 0 and incremented every cycle.
  - Every "on" LED (including lamp_test and heartbeat) is gated by (pwm_cnt < brightness) | (brightness == all-ones), inside the output register.
  - brightness = 0 makes all LEDs off; all-ones gives 100% duty.
- When undefined: no brightness port, no pwm_cnt, and LEDs are full on.

Test Plan:
Common parameters: CLK_FREQ_HZ=10000 (DIV=10), HB_PERIOD_MS=4, BLINK_PERIOD_MS=2, ACT_HOLD_MS=3, INVERT=0, CNT=2.
1. Reset release -> ticks at cycles 9, 19, 29…; hb_reg toggles after the tick at cycle 19; led_hb rises at cycle 21, falls at cycle 41, then toggles every 20 cycles.
2. ch_mode[0]=2, ch_link[0] toggled 0->1 at cycle 50 -> led_ch[0]=1 from cycle 51; ch_link cleared at cycle 80 -> led_ch[0]=0 from cycle 81.
3. Mode 3, link up, single ch_act pulse -> led_ch follows !blink_ph for 3 ticks (~30 cycles), then solid on; a second pulse coincident with a tick reloads hold_cnt to 3, not 2.
4. ch_fault[1]=1 with mode 1 -> led_ch[1] toggles every 10 cycles in phase with blink_ph; lamp_test=1 -> both LEDs and led_hb =1 next cycle regardless of mode 0.
5. rst_n pulled low for one cycle mid-blink with hold_cnt=2 -> all outputs 0 next cycle, first tick 9 cycles after release, hold_cnt=0 (mode-3 LED solid).
6. TAXI_LED_PWM_EN, PWM_W=4: brightness=4 with mode 1 -> led_ch high 4 of every 16 cycles; brightness=15 -> constant 1; brightness=0 -> constant 0.

Source files
------------

// File: rtl/taxi_led_status_ctrl.sv
// taxi_led_status_ctrl: board status LED controller.
// Drives one heartbeat LED and CNT port LEDs from a shared millisecond
// timebase. Each port LED has a selectable mode, activity stretching,
// blinking and fault indication. All LED pins are registered.
// Optional build macro TAXI_LED_PWM_EN adds a brightness input and a
// PWM gate on every LED.
module taxi_led_status_ctrl #(
  parameter int   CNT             = 2,
  parameter int   CLK_FREQ_HZ     = 125000000,
  parameter int   HB_PERIOD_MS    = 1000,
  parameter int   BLINK_PERIOD_MS = 100,
  parameter int   ACT_HOLD_MS     = 50,
  parameter logic INVERT          = 1'b1,
  parameter int   PWM_W           = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lamp_test,
  input  logic [CNT-1:0][1:0]   ch_mode,
  input  logic [CNT-1:0]        ch_link,
  input  logic [CNT-1:0]        ch_act,
  input  logic [CNT-1:0]        ch_fault,
`ifdef TAXI_LED_PWM_EN
  input  logic [PWM_W-1:0]      brightness,
`endif
  output logic                  led_hb,
  output logic [CNT-1:0]        led_ch
);

  localparam int DIV        = CLK_FREQ_HZ / 1000;
  localparam int HB_HALF    = HB_PERIOD_MS / 2;
  localparam int BLINK_HALF = BLINK_PERIOD_MS / 2;
  localparam int PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HB_W       = $clog2(HB_HALF + 1);
  localparam int BLINK_W    = $clog2(BLINK_HALF + 1);
  localparam int HOLD_W     = $clog2(ACT_HOLD_MS + 1);

  localparam logic LED_OFF = INVERT;
  localparam logic LED_ON  = ~INVERT;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_ON       = 2'd1,
    MODE_LINK     = 2'd2,
    MODE_LINK_ACT = 2'd3
  } mode_e;

  if (DIV < 2 || HB_PERIOD_MS < 2 || (HB_PERIOD_MS % 2) != 0 ||
      BLINK_PERIOD_MS < 2 || (BLINK_PERIOD_MS % 2) != 0 ||
      ACT_HOLD_MS < 1 || CNT < 1 || CNT > 32 || PWM_W < 1) begin : g_param_err
    $error("taxi_led_status_ctrl: invalid parameter combination");
  end

  logic [PRE_W-1:0]            presc_q, presc_d;
  logic [HB_W-1:0]             hb_cnt_q, hb_cnt_d;
  logic                        hb_q, hb_d;
  logic [BLINK_W-1:0]          blink_cnt_q, blink_cnt_d;
  logic                        blink_q, blink_d;
  logic [CNT-1:0][HOLD_W-1:0]  hold_q, hold_d;
  logic                        led_hb_q, led_hb_d;
  logic [CNT-1:0]              led_ch_q, led_ch_d;
  logic                        tick;
  logic                        pwm_on;
  logic [CNT-1:0]              ch_on;

`ifdef TAXI_LED_PWM_EN
  logic [PWM_W-1:0]            pwm_cnt_q;

  // Free-running PWM phase counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  assign pwm_on = (pwm_cnt_q < brightness) | (&brightness);
`else
  assign pwm_on = 1'b1;
`endif

  // Timebase, heartbeat, blink phase, activity hold and LED next values
  always_comb begin
    tick        = (presc_q == '0);
    presc_d     = tick ? PRE_W'(DIV - 1) : presc_q - 1'b1;
    hb_cnt_d    = hb_cnt_q;
    hb_d        = hb_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    hold_d      = hold_q;
    ch_on       = '0;
    led_ch_d    = '0;

    if (tick) begin
      if (hb_cnt_q == HB_W'(HB_HALF - 1)) begin
        hb_cnt_d = '0;
        hb_d     = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + 1'b1;
      end
      if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    for (int unsigned i = 0; i < CNT; i++) begin
      // A fresh activity pulse beats a concurrent tick decrement.
      if (ch_act[i]) begin
        hold_d[i] = HOLD_W'(ACT_HOLD_MS);
      end else if (tick && hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - 1'b1;
      end

      if (lamp_test) begin
        ch_on[i] = 1'b1;
      end else if (mode_e'(ch_mode[i]) == MODE_OFF) begin
        ch_on[i] = 1'b0;
      end else if (ch_fault[i]) begin
        ch_on[i] = blink_q;
      end else begin
        case (mode_e'(ch_mode[i]))
          MODE_ON:       ch_on[i] = 1'b1;
          MODE_LINK:     ch_on[i] = ch_link[i];
          MODE_LINK_ACT: ch_on[i] = ch_link[i] & ((hold_q[i] != '0) ? ~blink_q : 1'b1);
          default:       ch_on[i] = 1'b0;
        endcase
      end

      led_ch_d[i] = (ch_on[i] & pwm_on) ? LED_ON : LED_OFF;
    end

    led_hb_d = ((lamp_test | hb_q) & pwm_on) ? LED_ON : LED_OFF;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q     <= PRE_W'(DIV - 1);
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      hold_q      <= '0;
      led_hb_q    <= LED_OFF;
      led_ch_q    <= {CNT{LED_OFF}};
    end else begin
      presc_q     <= presc_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      hold_q      <= hold_d;
      led_hb_q    <= led_hb_d;
      led_ch_q    <= led_ch_d;
    end
  end

  assign led_hb = led_hb_q;
  assign led_ch = led_ch_q;

endmodule

// File: tb/tb_taxi_led_status_ctrl.sv
// Directed bench for taxi_led_status_ctrl.
// DIV=10, heartbeat half period 2 ticks, blink half period 1 tick,
// activity hold 3 ticks, active-high LEDs, 2 channels.
module tb_taxi_led_status_ctrl;

  logic             clk;
  logic             rst_n;
  logic             lamp_test;
  logic [1:0][1:0]  ch_mode;
  logic [1:0]       ch_link;
  logic [1:0]       ch_act;
  logic [1:0]       ch_fault;
  logic             led_hb;
  logic [1:0]       led_ch;
`ifdef TAXI_LED_PWM_EN
  logic [3:0]       brightness;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  taxi_led_status_ctrl #(
    .CNT             (2),
    .CLK_FREQ_HZ     (10000),
    .HB_PERIOD_MS    (4),
    .BLINK_PERIOD_MS (2),
    .ACT_HOLD_MS     (3),
    .INVERT          (1'b0),
    .PWM_W           (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lamp_test (lamp_test),
    .ch_mode   (ch_mode),
    .ch_link   (ch_link),
    .ch_act    (ch_act),
    .ch_fault  (ch_fault),
`ifdef TAXI_LED_PWM_EN
    .brightness(brightness),
`endif
    .led_hb    (led_hb),
    .led_ch    (led_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to the negedge inside cycle c (cycle 0 = first cycle after release).
  task automatic at(input int c);
    if (c > cyc) begin
      repeat (c - cyc) @(posedge clk);
      cyc = c;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    lamp_test = 1'b0;
    ch_mode   = '0;
    ch_link   = '0;
    ch_act    = '0;
    ch_fault  = '0;
`ifdef TAXI_LED_PWM_EN
    brightness = '1;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hb", 32'(led_hb), 32'd0);
    check("rst_ch", 32'(led_ch), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;

    // Heartbeat timing
    check("c0_hb", 32'(led_hb), 32'd0);
    check("c0_ch", 32'(led_ch), 32'd0);
    at(20); check("hb_c20", 32'(led_hb), 32'd0);
    at(21); check("hb_c21", 32'(led_hb), 32'd1);
    at(40); check("hb_c40", 32'(led_hb), 32'd1);
    at(41); check("hb_c41", 32'(led_hb), 32'd0);

    // Mode 2: link follows with one cycle latency
    at(45); ch_mode[0] = 2'd2;
    at(50); check("link_c50", 32'(led_ch), 32'd0); ch_link[0] = 1'b1;
    at(51); check("link_c51", 32'(led_ch), 32'd1);
    at(61); check("hb_c61", 32'(led_hb), 32'd1);
    at(80); check("link_c80", 32'(led_ch), 32'd1); ch_link[0] = 1'b0;
    at(81); check("link_c81", 32'(led_ch), 32'd0);

    // Mode 3: activity stretching and blinking
    at(85); ch_mode[0] = 2'd3; ch_link[0] = 1'b1;
    at(86); check("act_c86", 32'(led_ch), 32'd1);
    at(92); ch_act[0] = 1'b1;
    at(93); ch_act[0] = 1'b0; check("act_c93", 32'(led_ch), 32'd1);
    at(94);  check("act_c94",  32'(led_ch), 32'd0);
    at(100); check("act_c100", 32'(led_ch), 32'd0);
    at(101); check("act_c101", 32'(led_ch), 32'd1);
    at(110); check("act_c110", 32'(led_ch), 32'd1);
    at(111); check("act_c111", 32'(led_ch), 32'd0);
    at(120); check("act_c120", 32'(led_ch), 32'd0);
    at(121); check("act_c121", 32'(led_ch), 32'd1);
    // Pulse coincident with tick at cycle 129 reloads to 3
    at(129); ch_act[0] = 1'b1;
    at(130); ch_act[0] = 1'b0;
    at(131); check("act_c131", 32'(led_ch), 32'd0);
    at(141); check("act_c141", 32'(led_ch), 32'd1);
    at(155); check("act_c155", 32'(led_ch), 32'd0);
    at(161); check("act_c161", 32'(led_ch), 32'd1);

    // Fault blink on channel 1 (mode 1)
    at(165); ch_mode[1] = 2'd1; ch_fault[1] = 1'b1;
    at(170); check("flt_c170", 32'(led_ch), 32'd1);
    at(171); check("flt_c171", 32'(led_ch), 32'd3);
    at(180); check("flt_c180", 32'(led_ch), 32'd3);
    at(181); check("flt_c181", 32'(led_ch), 32'd1);
    // Mode 0 beats fault
    at(183); ch_mode[0] = 2'd0; ch_fault[0] = 1'b1;
    at(191); check("mode0_c191", 32'(led_ch), 32'd2);

    // Lamp test
    at(205); check("lamp_pre_hb", 32'(led_hb), 32'd0);
    check("lamp_pre_ch", 32'(led_ch), 32'd0);
    lamp_test = 1'b1;
    at(206); check("lamp_on_hb", 32'(led_hb), 32'd1);
    check("lamp_on_ch", 32'(led_ch), 32'd3);
    lamp_test = 1'b0;
    at(207); check("lamp_off_hb", 32'(led_hb), 32'd0);
    check("lamp_off_ch", 32'(led_ch), 32'd0);

    // Mid-operation reset with hold_cnt = 2
    at(210); ch_mode[0] = 2'd3; ch_fault[0] = 1'b0;
    at(215); ch_act[0] = 1'b1;
    at(216); ch_act[0] = 1'b0;
    at(222); rst_n = 1'b0;
    at(223); check("mrst_hb", 32'(led_hb), 32'd0);
    check("mrst_ch", 32'(led_ch), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    at(1);  check("mrst_c1_hb", 32'(led_hb), 32'd0);
    check("mrst_c1_ch", 32'(led_ch), 32'd1);
    at(10); check("mrst_c10_ch", 32'(led_ch), 32'd1);
    at(11); check("mrst_c11_ch", 32'(led_ch), 32'd3);
    at(20); check("mrst_c20_hb", 32'(led_hb), 32'd0);
    at(21); check("mrst_c21_hb", 32'(led_hb), 32'd1);

`ifdef TAXI_LED_PWM_EN
    // PWM duty on channel 1 (mode 1, no fault)
    at(25); ch_mode[1] = 2'd1; ch_fault[1] = 1'b0; brightness = 4'd4;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      at(26 + k);
      n += int'(led_ch[1]);
    end
    check("pwm_b4", 32'(n), 32'd4);
    at(42); brightness = 4'd0;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      at(43 + k);
      n += int'(led_ch[1]);
    end
    check("pwm_b0", 32'(n), 32'd0);
    at(59); brightness = 4'd15;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      at(60 + k);
      n += int'(led_ch[1]);
    end
    check("pwm_b15", 32'(n), 32'd16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
